// File: rtl/apb_arb_pkg.sv
// Shared types and default parameter values for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int DEF_N_REQ   = 2;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester
// after i_ptr (wrapping), skipping anyone in the exclude mask.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic [N_REQ-1:0] i_excl,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_valid
);

    logic [N_REQ-1:0] w_masked;

    assign w_masked = i_req & ~i_excl;

    // First masked request found after the pointer wins.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        logic             w_found;
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = PTR_W'((int'(i_ptr) + i) % N_REQ);
            if (!w_found && w_masked[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between N_REQ requesters: round-robin grant,
// command latch, SETUP/ACCESS sequencing, wait-state timeout, done/rdata/err return.
//
// state  | meaning
// IDLE   | bus quiet, waiting for any request
// SETUP  | PSEL high, PENABLE low, one cycle
// ACCESS | PSEL/PENABLE high until PREADY or timeout
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         req_write_i,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         done_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     err_o,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit TO_EN   = (TIMEOUT != 0);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [N_REQ-1:0]    r_gnt;
    logic [PTR_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;

    logic [N_REQ-1:0]    w_excl;
    logic [N_REQ-1:0]    w_arb_gnt;
    logic                w_arb_valid;
    logic [PTR_W-1:0]    w_win_idx;
    logic                w_win_write;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_timeout;
    logic                w_cmpl;
    logic                w_load;

    // The current owner must not win the back-to-back slot it is finishing.
    assign w_excl = (r_state == ACCESS) ? r_gnt : '0;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .i_excl  (w_excl),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    // Select the winner's command and index from the one-hot grant.
    always_comb begin
        w_win_idx   = '0;
        w_win_write = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_arb_gnt[k]) begin
                w_win_idx   = PTR_W'(k);
                w_win_write = req_write_i[k];
                w_win_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
                w_win_wdata = req_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout = TO_EN && (r_state == ACCESS) && !PREADY
                       && (r_cnt == CNT_W'(TO_LAST));
    assign w_cmpl    = (r_state == ACCESS) && (PREADY || w_timeout);

    // Next state, command-load strobe and completion outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        done_o      = '0;
        rdata_o     = '0;
        err_o       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = SETUP;
                    w_load      = 1'b1;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (w_cmpl) begin
                    done_o  = r_gnt;
                    rdata_o = PREADY ? PRDATA : '0;
                    err_o   = PREADY ? PSLVERR : 1'b1;
                    if (w_arb_valid) begin
                        w_state_nxt = SETUP;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, registered APB outputs, grant, pointer and wait counter.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_gnt     <= '0;
            r_ptr     <= PTR_W'(N_REQ - 1);
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= (w_state_nxt != IDLE);
            r_penable <= (w_state_nxt == ACCESS);
            if (w_load) begin
                r_pwrite <= w_win_write;
                r_paddr  <= w_win_addr;
                r_pwdata <= w_win_wdata;
                r_gnt    <= w_arb_gnt;
                r_ptr    <= w_win_idx;
                r_cnt    <= '0;
            end else begin
                if (w_state_nxt == IDLE) begin
                    r_gnt <= '0;
                end
                if ((r_state == ACCESS) && !PREADY) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign gnt_o   = r_gnt;

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Shares one APB master port between N_REQ internal requesters (CPU-side bridge, DMA/test port) and drives the GPIO slave through the full IDLE/SETUP/ACCESS protocol. Requesters see a simple req/done handshake. The block arbitrates round-robin, latches the winner's command, sequences PSEL/PENABLE, honours PREADY wait states, enforces a wait-state timeout and returns read data and error status to the winner.

## Interface
- N_REQ, 2: number of requesters (2..8)
- ADDR_W, 32: PADDR width
- DATA_W, 32: PWDATA/PRDATA width
- TIMEOUT, 16: max ACCESS cycles with PREADY low before abort; 0 disables
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- req_i  in  N_REQ  per-requester request level; held until that requester's done
- req_write_i  in  N_REQ  1 = write
- req_addr_i  in  N_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- req_wdata_i  in  N_REQ*DATA_W  packed write data
- gnt_o  out  N_REQ  one-hot, registered; high from SETUP through end of ACCESS
- done_o  out  N_REQ  one-hot completion pulse for the granted requester
- rdata_o  out  DATA_W  read data, valid when done_o != 0
- err_o  out  1  valid with done_o; PSLVERR or timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB controls
- PADDR  out  ADDR_W; PWDATA  out  DATA_W
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If any req_i is set, the round-robin winner is chosen: highest priority is the requester after the last granted, wrapping.
  - Winner's write/addr/wdata are latched into PWRITE/PADDR/PWDATA, gnt_o is set, and the next state is SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS. Unconditional.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWDATA, PWRITE and gnt_o are held stable.
  - PREADY=0: wait-state counter increments.
  - PREADY=1: done_o[winner]=1 and rdata_o=PRDATA (combinational that cycle); err_o=PSLVERR.
  - If another requester (excluding the current winner) has req_i=1, go directly to SETUP with the new winner latched (back-to-back, PSEL stays 1). Otherwise go to IDLE, and gnt_o clears.
  - Timeout: when TIMEOUT!=0 and the counter reaches TIMEOUT-1 with PREADY still 0, treat the cycle as completion with err_o=1 and rdata_o=0, then follow the same next-state rule.
- The round-robin pointer updates to the winner at each grant.
- The requester must deassert req_i in the cycle after its done pulse. A request still asserted in IDLE is a new transaction.
- Reset (PRESETn low at a rising edge, including mid-ACCESS):
  - State goes to IDLE; PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0; gnt_o = 0.
  - Pointer resets so requester 0 has top priority; counter = 0.
  - done_o and err_o are 0, since they are gated by ACCESS.
  - An aborted transfer produces no done.

## Timing
- req_i seen in IDLE at edge T: SETUP visible after T, ACCESS after T+1.
- Zero-wait completion: done_o is high during the ACCESS cycle, i.e. the 2nd cycle after the request edge.
- Each PREADY-low cycle adds one cycle.
- Back-to-back transfers: 2 cycles per transfer, with no IDLE gap.
- Wait counter width is clog2(TIMEOUT+1). It clears on entry to SETUP.
- All APB outputs and gnt_o are registered. done_o, rdata_o and err_o are combinational from PREADY/PRDATA/PSLVERR, qualified by state.

## Structure
- Package apb_arb_pkg:
  - state enum (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2)
  - default parameter constants
- Sub-module rr_arbiter (N_REQ): combinational. Inputs are the request vector, the pointer and an exclude mask. Outputs are the one-hot grant and a valid bit.
- The top holds the FSM, the latched command, the pointer and the wait counter.

## Test plan
- Reset, then req_i=01, write addr 0x04 data 0xA5, PREADY=1 -> SETUP then ACCESS with PADDR=0x04, PWDATA=0xA5, PWRITE=1; done_o=01 in the 2nd cycle; then IDLE.
- req_i=11 held continuously, PREADY=1 -> grants alternate 01,10,01,10; PSEL stays 1 across transfers; a done every 2 cycles.
- Read from requester 1 with PREADY low for 3 ACCESS cycles, PRDATA=0x5A on the 4th -> done_o=10, rdata_o=0x5A, err_o=0, ACCESS lasts 4 cycles.
- TIMEOUT=4, PREADY held 0 -> done_o pulses with err_o=1, rdata_o=0 on the 4th ACCESS cycle; then IDLE.
- PSLVERR=1 with PREADY=1 -> err_o=1 with done_o.
- PRESETn low during ACCESS -> the next cycle has PSEL=0, PENABLE=0, gnt_o=0, and no done_o. After release, req_i=11 grants requester 0 first.
